// File: rtl/load_store_unit.sv
// RV32I load/store stage: one request at a time, word-wide memory port with byte strobes, stall timeout.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses without touching memory.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_WIDTH    = 8
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   store_q, store_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic        illegal;
    logic        misalign;
    logic [31:0] steer_wdata;
    logic [3:0]  steer_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    always_comb begin
        if (req_store) illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else           illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Store data is replicated across all lanes; the strobes pick the lane(s) memory keeps.
    always_comb begin
        steer_wdata = 32'h0;
        steer_wstrb = 4'b0000;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    steer_wdata = {4{req_wdata[7:0]}};
                    steer_wstrb = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    steer_wdata = {2{req_wdata[15:0]}};
                    steer_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    steer_wdata = req_wdata;
                    steer_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d   = req_store;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    timer_d   = '0;
                    if (illegal || misalign) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = MEM;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = steer_wstrb;
                        mem_wdata_d = steer_wdata;
                    end
                end
            end
            MEM: begin
                // A ready arriving on the timeout cycle still completes the access normally.
                if (mem_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = store_q ? 32'h0 : load_data;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = (state_q == MEM);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule
